banked_mem_responder: RTL and testbench
=======================================

# banked_mem_responder

Four-bank, word-interleaved 16-bit main-memory model that answers the cache controller's memory port. It accepts one read or write request per cycle and rejects requests to an occupied bank, signalling a per-bank retry flag. Read data returns a fixed two cycles after acceptance, so the cache FSM can pipeline one request per bank across consecutive cycles. It sits below the direct-mapped cache and replaces the off-chip memory in cache-level benches.

## Interface
- BANK_CYCLES, 4: cycles a bank stays occupied after accepting a request, including the accept cycle; legal range 1..8.
- LFSR_SEED, 16'hACE1: reset seed of the stall-injection LFSR (used only with the macro).
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- addr  input  16  byte address; addr[2:1] is the bank, addr[15:3] is the row, addr[0] must be 0.
- data_in  input  16  write data.
- wr  input  1  write request this cycle.
- rd  input  1  read request this cycle.
- data_out  output  16  read data; valid exactly 2 cycles after an accepted read, 0 otherwise.
- stall  output  1  combinational; the current request is not accepted.
- busy  output  4  registered; busy[b]=1 in cycle t+1 if a request to bank b in cycle t was rejected.
- err  output  1  combinational; the current request is illegal and ignored.

## Operation
- Storage: four banks, each 8192 x 16, indexed by addr[15:3]. Contents are not cleared by rst; uninitialised words read as X.
- Per-bank occupancy counter occ[b], 3 bits. Bank b is free when occ[b]==0.
- Request present = rd|wr. Illegal when rd&wr, or addr[0]==1: err=1, stall=0, no access, occ and busy unchanged for that bank.
- Legal request to a free bank: accepted. occ[b] loads BANK_CYCLES-1. Write stores data_in at the end of the cycle. Read samples the array in the accept cycle and enters a 2-stage return pipeline.
- Legal request to an occupied bank: stall=1, no access, busy[b]=1 next cycle. All other busy bits are 0 next cycle.
- Each cycle every nonzero occ[b] decrements, except a bank loaded in that cycle.
- At most one request per cycle, so the four banks never conflict with one another.
- Read-after-write to the same address is safe: a write in cycle t is visible to any read accepted in cycle t+1 or later.

## Timing
- Reset values: data_out=0, busy=4'b0000, occ[*]=0, return pipeline empty. stall and err follow their inputs combinationally (0 when rd=wr=0).
- Read accepted in cycle t: data_out shows the word in cycle t+2 only. In all other cycles data_out=0.
- Write accepted in cycle t has no return traffic.
- Same bank: earliest next acceptance is cycle t+BANK_CYCLES. Different banks: acceptance every cycle.
- busy is a one-cycle retry pulse. The requester re-issues the identical request while busy[b]=1.
- rst asserted mid-operation: in-flight reads are discarded (data_out=0 from the next cycle), all banks free, busy cleared. A request present in the reset cycle is not accepted and does not write.
- BANK_CYCLES=1: a bank is never occupied, so stall comes only from the macro.

## Configuration
- BANKED_MEM_RAND_STALL_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; loads LFSR_SEED on rst) advances every cycle.
  - A legal request to a free bank is also rejected when lfsr[3:0]==4'h0. This is treated exactly like an occupied bank: stall=1, busy[b]=1 next cycle.
  - Purpose: stress requester retry paths.
- Not defined: no LFSR; rejection only from occupancy.

## Test plan
- Reset, then wr addr=16'h0010 data_in=16'hBEEF, then rd 16'h0010 four cycles later -> data_out=16'hBEEF exactly 2 cycles after the read, 0 on neighbouring cycles.
- Burst reads to 16'h1230, 16'h1232, 16'h1234, 16'h1236 on consecutive cycles -> no stall, four words returned on cycles t+2..t+5 in order.
- BANK_CYCLES=4: rd 16'h0000 at t and again at t+1 -> second request stall=1, busy=4'b0001 at t+2; re-issue at t+4 is accepted.
- rd=wr=1, or addr=16'h0003 -> err=1, memory unchanged, busy=0, data_out stays 0.
- Read accepted at t, rst at t+1 -> data_out=0 at t+2; a new read to the same bank at t+2 is accepted.
- With BANKED_MEM_RAND_STALL_EN: 10k random legal requests with retry-on-busy -> every read matches the scoreboard; at least one stall on a free bank is observed.

Source files
------------

// File: rtl/banked_mem_responder_if.sv
// Memory-port bundle between the cache controller (master) and the
// banked main-memory model (slave).
interface banked_mem_responder_if;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic        rd;
    logic [15:0] data_out;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    modport master (
        output addr, data_in, wr, rd,
        input  data_out, stall, busy, err
    );

    modport slave (
        input  addr, data_in, wr, rd,
        output data_out, stall, busy, err
    );
endinterface

// File: rtl/banked_mem_responder.sv
// Four-bank, word-interleaved 16-bit main-memory model.
// addr[2:1] selects the bank, addr[15:3] the row. One request per cycle;
// a request to an occupied bank is rejected (stall) and flagged on busy
// the following cycle. Read data returns exactly two cycles after accept.
// Optional feature macro: BANKED_MEM_RAND_STALL_EN adds LFSR-driven
// rejections of requests to free banks to exercise requester retry logic.
module banked_mem_responder #(
    parameter int          BANK_CYCLES = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    banked_mem_responder_if.slave mem_bus
);
    // Occupancy count loaded on accept; the accept cycle itself counts.
    localparam logic [2:0] OCC_LOAD = 3'(BANK_CYCLES - 1);

    logic        req;
    logic        illegal;
    logic        legal;
    logic        bank_occ;
    logic        rand_stall;
    logic        reject;
    logic        accept;
    logic [1:0]  bank;
    logic [12:0] row;

    logic [2:0]  occ_cur [4];
    logic [15:0] rd_word [4];

    logic [3:0]  busy_q, busy_d;
    logic        rd_vld_q, rd_vld_d;
    logic [1:0]  rd_bank_q, rd_bank_d;
    logic [15:0] data_out_q, data_out_d;

    assign req      = mem_bus.rd | mem_bus.wr;
    assign illegal  = req & ((mem_bus.rd & mem_bus.wr) | mem_bus.addr[0]);
    assign legal    = req & ~illegal;
    assign bank     = mem_bus.addr[2:1];
    assign row      = mem_bus.addr[15:3];
    assign bank_occ = (occ_cur[bank] != 3'd0);
    assign reject   = legal & (bank_occ | rand_stall);
    // Nothing is accepted in a reset cycle, so a write there never lands.
    assign accept   = legal & ~reject & ~rst;

    assign mem_bus.stall    = reject;
    assign mem_bus.err      = illegal;
    assign mem_bus.busy     = busy_q;
    assign mem_bus.data_out = data_out_q;

`ifdef BANKED_MEM_RAND_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB.
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // LFSR advances every cycle and restarts from the seed on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rand_stall = (lfsr_q[3:0] == 4'h0);
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
    assign rand_stall  = 1'b0;
`endif

    // One-hot retry pulse for the bank whose request was just rejected.
    always_comb begin
        busy_d = '0;
        if (reject) begin
            busy_d[bank] = 1'b1;
        end
    end

    assign rd_vld_d   = accept & mem_bus.rd;
    assign rd_bank_d  = bank;
    assign data_out_d = rd_vld_q ? rd_word[rd_bank_q] : 16'h0000;

    // Return pipeline: stage 1 is the bank's registered array read,
    // stage 2 is the output register that is zero unless a read returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            rd_vld_q   <= 1'b0;
            rd_bank_q  <= 2'd0;
            data_out_q <= 16'h0000;
        end else begin
            busy_q     <= busy_d;
            rd_vld_q   <= rd_vld_d;
            rd_bank_q  <= rd_bank_d;
            data_out_q <= data_out_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bank
            logic [2:0]  occ_q, occ_d;
            logic [15:0] mem_q [8192];
            logic [15:0] rdata_q;
            logic        sel;

            assign sel = accept && (bank == 2'(gi));

            // Occupancy: reload on accept, otherwise count down to free.
            always_comb begin
                occ_d = occ_q;
                if (sel) begin
                    occ_d = OCC_LOAD;
                end else if (occ_q != 3'd0) begin
                    occ_d = occ_q - 3'd1;
                end
            end

            // Occupancy register; reset frees the bank.
            always_ff @(posedge clk) begin
                if (rst) begin
                    occ_q <= 3'd0;
                end else begin
                    occ_q <= occ_d;
                end
            end

            // Bank storage with registered read; contents survive reset.
            always_ff @(posedge clk) begin
                if (sel && mem_bus.wr) begin
                    mem_q[row] <= mem_bus.data_in;
                end
                if (sel && mem_bus.rd) begin
                    rdata_q <= mem_q[row];
                end
            end

            assign occ_cur[gi] = occ_q;
            assign rd_word[gi] = rdata_q;
        end
    endgenerate
endmodule

// File: tb/tb_banked_mem_responder.sv
// Self-checking bench for banked_mem_responder. A behavioural model tracks
// when each bank becomes free again, the stored words, and the expected
// data_out / busy value for every cycle number.
module tb_banked_mem_responder;
    localparam int BC = 4;
`ifdef BANKED_MEM_RAND_STALL_EN
    localparam int NRAND = 10000;
`else
    localparam int NRAND = 3000;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    banked_mem_responder_if bus();

    banked_mem_responder #(.BANK_CYCLES(BC)) dut (
        .clk     (clk),
        .rst     (rst),
        .mem_bus (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int free_stalls = 0;
    int free_at [4];
    logic [15:0] mem_m [int];
    logic [15:0] exp_dout [int];
    logic [3:0]  exp_busy [int];

    logic        e_stall, e_err, acc;
    logic [15:0] e_dout;
    logic [3:0]  e_busy;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Model of one cycle: bank b is occupied until cycle free_at[b].
    task automatic model_step(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        bit req;
        bit occupied;
        int b;
        int key;
        req = r | w;
        b = int'(a[2:1]);
        key = int'(a >> 1);
        occupied = (cyc < free_at[b]);
        e_err = req && ((r && w) || a[0]);
        e_stall = req && !e_err && occupied;
`ifdef BANKED_MEM_RAND_STALL_EN
        if (req && !e_err && !occupied && bus.stall === 1'b1) begin
            e_stall = 1'b1;
            free_stalls++;
        end
`endif
        e_dout = exp_dout.exists(cyc) ? exp_dout[cyc] : 16'h0000;
        e_busy = exp_busy.exists(cyc) ? exp_busy[cyc] : 4'b0000;
        acc = req && !e_err && !e_stall && !rst;
        if (rst) begin
            for (int i = 0; i < 4; i++) free_at[i] = cyc + 1;
            exp_dout.delete(cyc + 1);
            exp_busy[cyc + 1] = 4'b0000;
        end else if (e_stall) begin
            exp_busy[cyc + 1] = 4'b0001 << b;
        end
        if (acc) begin
            free_at[b] = cyc + BC;
            if (w) mem_m[key] = d;
            if (r) exp_dout[cyc + 2] = mem_m.exists(key) ? mem_m[key] : 16'h0000;
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        bus.rd = r;
        bus.wr = w;
        bus.addr = a;
        bus.data_in = d;
        #1;
        model_step(r, w, a, d);
    endtask

    // Issue a request and re-issue it every cycle until accepted.
    task automatic issue(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d, output int t_acc);
        t_acc = -1;
        for (int k = 0; k < 40 && t_acc < 0; k++) begin
            drive(r, w, a, d);
            checks++;
            if (bus.stall !== e_stall) begin
                failures++;
                $display("FAIL issue_stall cyc=%0d addr=%h got=%b exp=%b", cyc, a, bus.stall, e_stall);
            end
            if (acc) t_acc = cyc;
            tick();
        end
        checks++;
        if (t_acc < 0) begin
            failures++;
            $display("FAIL issue_timeout addr=%h got=no_accept exp=accept", a);
        end
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 1'b0, 16'h0000, 16'h0000);
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 16'h0000, 16'h0000);
            checks++;
            if (bus.stall !== 1'b0 || bus.err !== 1'b0) begin
                failures++;
                $display("FAIL reset_comb got=%b%b exp=00", bus.stall, bus.err);
            end
            tick();
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++;
        if (bus.data_out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_data_out got=%h exp=0000", bus.data_out);
        end
        checks++;
        if (bus.busy !== 4'b0000) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0000", bus.busy);
        end
        tick();
        $display("test_reset done cyc=%0d", cyc);
    endtask

    task automatic test_write_read();
        int tw, tr;
        logic [15:0] exp;
        issue(1'b0, 1'b1, 16'h0010, 16'hBEEF, tw);
        while (cyc < tw + 4) idle(1);
        issue(1'b1, 1'b0, 16'h0010, 16'h0000, tr);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 16'h0000, 16'h0000);
            exp = (cyc == tr + 2) ? 16'hBEEF : 16'h0000;
            checks++;
            if (bus.data_out !== exp) begin
                failures++;
                $display("FAIL write_read_data cyc=%0d got=%h exp=%h", cyc, bus.data_out, exp);
            end
            tick();
        end
        $display("test_write_read wr@%0d rd@%0d", tw, tr);
    endtask

    task automatic test_burst();
        int t;
        logic [15:0] a;
        for (int i = 0; i < 4; i++) begin
            a = 16'h1230 + 16'(2 * i);
            issue(1'b0, 1'b1, a, 16'($urandom), t);
        end
        idle(BC);
        for (int i = 0; i < 4; i++) begin
            a = 16'h1230 + 16'(2 * i);
            drive(1'b1, 1'b0, a, 16'h0000);
            checks++;
            if (bus.stall !== e_stall) begin
                failures++;
                $display("FAIL burst_stall addr=%h got=%b exp=%b", a, bus.stall, e_stall);
            end
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b0, 16'h0000, 16'h0000);
            checks++;
            if (bus.data_out !== e_dout) begin
                failures++;
                $display("FAIL burst_data cyc=%0d got=%h exp=%h", cyc, bus.data_out, e_dout);
            end
            tick();
        end
        $display("test_burst done cyc=%0d", cyc);
    endtask

    task automatic test_bank_conflict();
        int t;
        issue(1'b0, 1'b1, 16'h0000, 16'h5A5A, t);
        idle(BC);
        issue(1'b1, 1'b0, 16'h0000, 16'h0000, t);
        // issue() leaves us in cycle t+1 with inputs idle
        drive(1'b1, 1'b0, 16'h0000, 16'h0000);
        checks++;
        if (bus.stall !== 1'b1) begin
            failures++;
            $display("FAIL conflict_stall got=%b exp=1", bus.stall);
        end
        tick();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++;
        if (bus.busy !== 4'b0001) begin
            failures++;
            $display("FAIL conflict_busy got=%b exp=0001", bus.busy);
        end
        tick();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++;
        if (bus.busy !== 4'b0000) begin
            failures++;
            $display("FAIL conflict_busy_clear got=%b exp=0000", bus.busy);
        end
        tick();
        drive(1'b1, 1'b0, 16'h0000, 16'h0000);
        checks++;
        if (bus.stall !== e_stall || cyc != t + 4) begin
            failures++;
            $display("FAIL conflict_reissue cyc=%0d got=%b exp=%b", cyc, bus.stall, e_stall);
        end
        tick();
        idle(3);
        $display("test_bank_conflict rd@%0d reissue@%0d", t, t + 4);
    endtask

    task automatic test_illegal();
        int t;
        issue(1'b0, 1'b1, 16'h0002, 16'h1357, t);
        idle(BC);
        drive(1'b1, 1'b1, 16'h0002, 16'h1111);
        checks++;
        if (bus.err !== 1'b1 || bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL illegal_rdwr got=err%b/stall%b exp=err1/stall0", bus.err, bus.stall);
        end
        tick();
        drive(1'b0, 1'b1, 16'h0003, 16'h2222);
        checks++;
        if (bus.err !== 1'b1) begin
            failures++;
            $display("FAIL illegal_odd_wr got=%b exp=1", bus.err);
        end
        tick();
        drive(1'b1, 1'b0, 16'h0003, 16'h0000);
        checks++;
        if (bus.err !== 1'b1) begin
            failures++;
            $display("FAIL illegal_odd_rd got=%b exp=1", bus.err);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 16'h0000, 16'h0000);
            checks++;
            if (bus.busy !== 4'b0000 || bus.data_out !== 16'h0000) begin
                failures++;
                $display("FAIL illegal_quiet got=busy%b/data%h exp=busy0000/data0000", bus.busy, bus.data_out);
            end
            tick();
        end
        issue(1'b1, 1'b0, 16'h0002, 16'h0000, t);
        idle(1);
        checks++;
        if (bus.data_out !== 16'h1357) begin
            failures++;
            $display("FAIL illegal_mem_unchanged got=%h exp=1357", bus.data_out);
        end
        idle(2);
        $display("test_illegal done cyc=%0d", cyc);
    endtask

    task automatic test_reset_midflight();
        int t;
        issue(1'b0, 1'b1, 16'h0040, 16'hA0A0, t);
        issue(1'b0, 1'b1, 16'h0048, 16'hC3C3, t);
        while (cyc < t + BC) idle(1);
        issue(1'b1, 1'b0, 16'h0040, 16'h0000, t);
        rst = 1'b1;
        drive(1'b0, 1'b1, 16'h0048, 16'hDEAD);
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, 16'h0048, 16'h0000);
        checks++;
        if (bus.data_out !== 16'h0000) begin
            failures++;
            $display("FAIL rst_flush_data got=%h exp=0000", bus.data_out);
        end
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL rst_bank_free got=%b exp=0", bus.stall);
        end
        tick();
        idle(1);
        checks++;
        if (bus.data_out !== 16'hC3C3) begin
            failures++;
            $display("FAIL rst_no_write got=%h exp=c3c3", bus.data_out);
        end
        idle(2);
        $display("test_reset_midflight rd@%0d rst@%0d", t, t + 1);
    endtask

    task automatic test_random();
        logic [15:0] pool [32];
        bit written [32];
        int slot, kind, t_acc;
        logic r, w;
        logic [15:0] a, d;
        for (int i = 0; i < 32; i++) begin
            pool[i] = 16'($urandom) & 16'hFFFE;
            written[i] = 1'b0;
        end
        idle(BC);
        for (int n = 0; n < NRAND; n++) begin
            slot = $urandom_range(0, 31);
            kind = $urandom_range(0, 15);
            a = pool[slot];
            d = 16'($urandom);
            if (kind == 0) begin
                r = 1'b1;
                w = $urandom_range(0, 1) == 1;
                if (!w) a = a | 16'h0001;
                drive(r, w, a, d);
                checks++;
                if (bus.err !== 1'b1 || bus.data_out !== e_dout || bus.busy !== e_busy) begin
                    failures++;
                    $display("FAIL rand_illegal n=%0d got=err%b/%h/%b exp=err1/%h/%b", n, bus.err, bus.data_out, bus.busy, e_dout, e_busy);
                end
                tick();
            end else begin
                w = !written[slot] || ($urandom_range(0, 1) == 1);
                r = !w;
                t_acc = -1;
                for (int k = 0; k < 40 && t_acc < 0; k++) begin
                    drive(r, w, a, d);
                    checks++;
                    if (bus.stall !== e_stall || bus.err !== 1'b0 || bus.data_out !== e_dout || bus.busy !== e_busy) begin
                        failures++;
                        $display("FAIL rand_cycle n=%0d cyc=%0d got=stall%b err%b %h %b exp=stall%b err0 %h %b",
                                 n, cyc, bus.stall, bus.err, bus.data_out, bus.busy, e_stall, e_dout, e_busy);
                    end
                    if (acc) t_acc = cyc;
                    tick();
                end
                checks++;
                if (t_acc < 0) begin
                    failures++;
                    $display("FAIL rand_timeout n=%0d got=no_accept exp=accept", n);
                end else if (w) begin
                    written[slot] = 1'b1;
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 16'h0000, 16'h0000);
            checks++;
            if (bus.data_out !== e_dout) begin
                failures++;
                $display("FAIL rand_drain got=%h exp=%h", bus.data_out, e_dout);
            end
            tick();
        end
`ifdef BANKED_MEM_RAND_STALL_EN
        checks++;
        if (free_stalls == 0) begin
            failures++;
            $display("FAIL rand_free_stall got=%0d exp=>0", free_stalls);
        end
`endif
        $display("test_random n=%0d free_bank_stalls=%0d cyc=%0d", NRAND, free_stalls, cyc);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) free_at[i] = 0;
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        bus.addr = 16'h0000;
        bus.data_in = 16'h0000;
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_burst();
        test_bank_conflict();
        test_illegal();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
